// File: rtl/operand_sequencer.sv
// operand_sequencer: host-side transmitter that loads x, dx, a, u onto a shared bus with one-hot
// strobes s1..s4, then runs the ready/valid handshake. Optional WAIT_VALID watchdog: OPSEQ_TIMEOUT_EN.
module operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] dx_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] u_in,
  input  logic [3:0]       ctrl_state,
  input  logic             valid,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] data_out,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y_out,
  output logic             err
);

  localparam int                HOLD_W     = (HOLD > 32'sd1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD - 32'sd1);
  localparam logic [3:0]        READ_STATE = 4'd1;

  if (HOLD < 32'sd1 || TIMEOUT < 32'sd1) begin : g_bad_param
    $error("operand_sequencer: HOLD and TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READ  = 3'd1,
    ST_SEND       = 3'd2,
    ST_GAP        = 3'd3,
    ST_READY      = 3'd4,
    ST_WAIT_VALID = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [1:0]        idx_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [WIDTH-1:0]  op_r [4];
  logic              in_read_s;
  logic              hold_last_s;
  logic              timeout_s;
  logic [3:0]        strobe_s;
  logic              ready_s;
  logic              busy_s;
  logic              done_s;
  logic [WIDTH-1:0]  data_s;

  assign in_read_s   = (ctrl_state == READ_STATE);
  assign hold_last_s = (hold_cnt_r == HOLD_LAST);

`ifdef OPSEQ_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 32'sd1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 32'sd1);

  logic [TO_W-1:0] to_cnt_r;

  assign timeout_s = (state_r == ST_WAIT_VALID) && !valid && (to_cnt_r == TO_LAST);

  // Watchdog counter, live only while waiting for valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_WAIT_VALID) begin
      to_cnt_r <= to_cnt_r + TO_W'(1'b1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  // Sticky timeout flag, cleared by the next accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      err <= 1'b0;
    end else if (timeout_s) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; losing the read state during SEND/GAP abandons the load
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:       if (start) next_state_s = ST_WAIT_READ; else next_state_s = ST_IDLE;
      ST_WAIT_READ:  if (in_read_s) next_state_s = ST_SEND; else next_state_s = ST_WAIT_READ;
      ST_SEND: begin
        if (!in_read_s)       next_state_s = ST_IDLE;
        else if (hold_last_s) next_state_s = ST_GAP;
        else                  next_state_s = ST_SEND;
      end
      ST_GAP: begin
        if (!in_read_s)          next_state_s = ST_IDLE;
        else if (idx_r == 2'd3)  next_state_s = ST_READY;
        else                     next_state_s = ST_SEND;
      end
      ST_READY:      if (!in_read_s) next_state_s = ST_WAIT_VALID; else next_state_s = ST_READY;
      ST_WAIT_VALID: begin
        if (valid)          next_state_s = ST_DONE;
        else if (timeout_s) next_state_s = ST_IDLE;
        else                next_state_s = ST_WAIT_VALID;
      end
      ST_DONE:       next_state_s = ST_IDLE;
      default:       next_state_s = ST_IDLE;
    endcase
  end

  // Output decode of the current state, registered below
  always_comb begin
    strobe_s = 4'b0000;
    ready_s  = 1'b0;
    done_s   = 1'b0;
    busy_s   = (state_r != ST_IDLE);
    data_s   = data_out;
    case (state_r)
      ST_SEND: begin
        strobe_s = 4'b0001 << idx_r;
        data_s   = op_r[idx_r];
      end
      ST_READY: ready_s = 1'b1;
      ST_DONE:  done_s  = 1'b1;
      default:  strobe_s = 4'b0000;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {s4, s3, s2, s1} <= 4'b0000;
      ready            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      data_out         <= '0;
    end else begin
      {s4, s3, s2, s1} <= strobe_s;
      ready            <= ready_s;
      busy             <= busy_s;
      done             <= done_s;
      data_out         <= data_s;
    end
  end

  // Operand latch, send index, hold counter and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r[0]    <= '0;
      op_r[1]    <= '0;
      op_r[2]    <= '0;
      op_r[3]    <= '0;
      idx_r      <= 2'd0;
      hold_cnt_r <= '0;
      y_out      <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_r      <= 2'd0;
          hold_cnt_r <= '0;
          if (start) begin
            op_r[0] <= x_in;
            op_r[1] <= dx_in;
            op_r[2] <= a_in;
            op_r[3] <= u_in;
          end
        end
        ST_WAIT_READ:  idx_r <= 2'd0;
        ST_SEND:       hold_cnt_r <= (next_state_s == ST_SEND) ? hold_cnt_r + HOLD_W'(1'b1) : '0;
        ST_GAP:        if (idx_r != 2'd3) idx_r <= idx_r + 2'd1;
        ST_WAIT_VALID: if (valid) y_out <= y_in;
        default:       idx_r <= idx_r;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed protocol scenarios plus randomized transactions, checked every
// cycle against a behavioural model of the sequencer's timing rules.
module tb_operand_sequencer;
  localparam int W    = 16;
  localparam int HOLD = 2;
  localparam int TO   = 8;
  localparam int SLOT = HOLD + 1;

  localparam int M_IDLE = 0, M_WREAD = 1, M_SEND = 2, M_READY = 3, M_WVALID = 4, M_DONE = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x_in = '0, dx_in = '0, a_in = '0, u_in = '0, y_in = '0;
  logic [3:0]   ctrl_state = 4'd0;
  logic         valid = 1'b0;
  logic [W-1:0] data_out, y_out;
  logic         s1, s2, s3, s4, ready, busy, done, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_seen = 0;

  // model state
  int           m_mode = M_IDLE;
  int           m_k = 0;
  int           m_wcnt = 0;
  logic [W-1:0] m_ops [4];
  logic [3:0]   e_s = 4'b0;
  logic         e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [W-1:0] e_data = '0, e_y = '0;

  operand_sequencer #(.WIDTH(W), .HOLD(HOLD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .dx_in(dx_in), .a_in(a_in), .u_in(u_in),
    .ctrl_state(ctrl_state), .valid(valid), .y_in(y_in),
    .data_out(data_out), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .ready(ready), .busy(busy), .done(done), .y_out(y_out), .err(err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: outputs seen after an edge are decoded from the mode held before it;
  // y_out and err update at the edge itself.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode = M_IDLE; m_k = 0; m_wcnt = 0;
      for (int i = 0; i < 4; i++) m_ops[i] = '0;
      e_s = 4'b0; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_err = 1'b0; e_data = '0; e_y = '0;
    end else begin
      e_s     = 4'b0;
      e_ready = (m_mode == M_READY);
      e_done  = (m_mode == M_DONE);
      e_busy  = (m_mode != M_IDLE);
      if (m_mode == M_SEND && (m_k % SLOT) < HOLD) begin
        e_s[m_k / SLOT] = 1'b1;
        e_data = m_ops[m_k / SLOT];
      end
      case (m_mode)
        M_IDLE: if (start) begin
          m_ops[0] = x_in; m_ops[1] = dx_in; m_ops[2] = a_in; m_ops[3] = u_in;
          e_err = 1'b0;
          m_mode = M_WREAD;
        end
        M_WREAD: if (ctrl_state == 4'd1) begin m_mode = M_SEND; m_k = 0; end
        M_SEND: begin
          if (ctrl_state != 4'd1) m_mode = M_IDLE;
          else if (m_k + 1 == 4 * SLOT) m_mode = M_READY;
          else m_k++;
        end
        M_READY: if (ctrl_state != 4'd1) begin m_mode = M_WVALID; m_wcnt = 0; end
        M_WVALID: begin
          if (valid) begin
            e_y = y_in;
            m_mode = M_DONE;
          end else begin
            m_wcnt++;
`ifdef OPSEQ_TIMEOUT_EN
            if (m_wcnt == TO) begin e_err = 1'b1; m_mode = M_IDLE; end
`endif
          end
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (done) done_seen++;
    chk("strobes", {s4, s3, s2, s1}, e_s);
    chk("ready", ready, e_ready);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("data_out", data_out, e_data);
    chk("y_out", y_out, e_y);
    chk("err", err, e_err);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic goto(input int n);
    while (cyc < n) begin @(posedge clk); #2; end
  endtask

  task automatic at_neg(input int n);
    goto(n);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {s4, s3, s2, s1}, 4'b0);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_data"}, data_out, 16'h0000);
    chk({tag, "_y"}, y_out, 16'h0000);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  task automatic launch(input logic [3:0] cs, output int e);
    goto(cyc + 1);
    ctrl_state = cs;
    start = 1'b1;
    e = cyc + 1;
    goto(e);
    start = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (m_mode != M_IDLE && n < limit) begin goto(cyc + 1); n++; end
    valid = 1'b0;
    goto(cyc + 1);
    @(negedge clk);
    chk("drain_idle", busy, 1'b0);
  endtask

  task automatic full_seq(input logic [W-1:0] x, dx, a, u, y);
    int e, d0;
    x_in = x; dx_in = dx; a_in = a; u_in = u;
    launch(4'd1, e);
    at_neg(e + 1);  chk("s1_early", s1, 1'b0);
    at_neg(e + 2);  chk("s1_E+2", s1, 1'b1);  chk("data_x", data_out, x);
    at_neg(e + 5);  chk("s2_E+5", s2, 1'b1);  chk("data_dx", data_out, dx);
    at_neg(e + 8);  chk("s3_E+8", s3, 1'b1);  chk("data_a", data_out, a);
    at_neg(e + 11); chk("s4_E+11", s4, 1'b1); chk("data_u", data_out, u);
    at_neg(e + 13); chk("ready_E+13", ready, 1'b0);
    at_neg(e + 14); chk("ready_E+14", ready, 1'b1);
    goto(e + 15);   ctrl_state = 4'd2;
    at_neg(e + 16); chk("ready_hold", ready, 1'b1);
    at_neg(e + 17); chk("ready_drop", ready, 1'b0);
    d0 = done_seen;
    goto(e + 20);   valid = 1'b1; y_in = y;
    goto(e + 21);   valid = 1'b0;
    at_neg(e + 21); chk("y_capture", y_out, y);
    at_neg(e + 22); chk("done_pulse", done, 1'b1); chk("busy_with_done", busy, 1'b1);
    at_neg(e + 23); chk("done_end", done, 1'b0); chk("busy_fall", busy, 1'b0);
    chk("done_once", done_seen - d0, 1);
  endtask

  initial begin
    int e, d0, n;
    at_neg(1);
    chk_all_zero("reset");
    goto(2);
    reset = 1'b0;

    full_seq(16'h0010, 16'h0001, 16'h0003, 16'h0005, 16'h1234);

    // reset mid-SEND, during s2
    x_in = 16'hA001; dx_in = 16'hA002; a_in = 16'hA003; u_in = 16'hA004;
    launch(4'd1, e);
    goto(e + 5);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    goto(e + 6);
    reset = 1'b0;
    full_seq(16'h0BAD, 16'h0C0D, 16'h00EF, 16'h7777, 16'hBEEF);

    // wait for the read state, then a start during SEND that must be ignored
    x_in = 16'h1111; dx_in = 16'h2222; a_in = 16'h3333; u_in = 16'h4444;
    launch(4'd0, e);
    at_neg(e + 3);  chk("wr_busy", busy, 1'b1); chk("wr_no_s1", s1, 1'b0);
    goto(e + 5);    ctrl_state = 4'd1;
    at_neg(e + 6);  chk("wr_s1_wait", s1, 1'b0);
    at_neg(e + 7);  chk("wr_s1", s1, 1'b1); chk("wr_data_x", data_out, 16'h1111);
    goto(e + 8);    start = 1'b1; x_in = 16'hFFFF; dx_in = 16'hEEEE; a_in = 16'hDDDD; u_in = 16'hCCCC;
    goto(e + 9);    start = 1'b0;
    at_neg(e + 10); chk("wr_s2", s2, 1'b1); chk("wr_data_dx", data_out, 16'h2222);
    at_neg(e + 16); chk("wr_s4", s4, 1'b1); chk("wr_data_u", data_out, 16'h4444);
    at_neg(e + 19); chk("wr_ready", ready, 1'b1);
    goto(e + 20);   ctrl_state = 4'd3; valid = 1'b1; y_in = 16'h5A5A;
    drain(50);
    chk("wr_y_early_valid", y_out, 16'h5A5A);

    // abort during s3
    d0 = done_seen;
    launch(4'd1, e);
    goto(e + 8);    ctrl_state = 4'd0;
    at_neg(e + 9);  chk("ab_s3", s3, 1'b1);
    at_neg(e + 10); chk("ab_strobes", {s4, s3, s2, s1}, 4'b0); chk("ab_busy", busy, 1'b0);
    at_neg(e + 20); chk("ab_no_done", done_seen - d0, 0);

    // no valid: watchdog or indefinite wait
    d0 = done_seen;
    valid = 1'b0;
    launch(4'd1, e);
    goto(e + 15);   ctrl_state = 4'd2;
`ifdef OPSEQ_TIMEOUT_EN
    at_neg(e + 23); chk("to_err_pre", err, 1'b0); chk("to_busy_pre", busy, 1'b1);
    at_neg(e + 25); chk("to_err", err, 1'b1); chk("to_idle", busy, 1'b0);
    chk("to_no_done", done_seen - d0, 0);
`else
    at_neg(e + 116); chk("nto_busy", busy, 1'b1); chk("nto_err", err, 1'b0);
    goto(e + 117);  valid = 1'b1; y_in = 16'h0042;
    drain(20);
`endif

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      goto(cyc + 1);
      x_in = W'($urandom); dx_in = W'($urandom); a_in = W'($urandom); u_in = W'($urandom);
      valid = 1'b0;
      launch(($urandom_range(0, 1) == 0) ? 4'd1 : 4'd0, e);
      n = 0;
      while (m_mode != M_IDLE && n < 300) begin
        start = 1'b0;
        case (m_mode)
          M_WREAD: if ($urandom_range(0, 2) == 0) ctrl_state = 4'd1;
          M_SEND: begin
            ctrl_state = ($urandom_range(0, 60) == 0) ? 4'd0 : 4'd1;
            if ($urandom_range(0, 5) == 0) begin start = 1'b1; x_in = W'($urandom); end
          end
          M_READY: if ($urandom_range(0, 1) == 0) begin
            ctrl_state = 4'($urandom_range(2, 15));
            valid = ($urandom_range(0, 3) == 0);
            y_in = W'($urandom);
          end
          M_WVALID: begin
            valid = ($urandom_range(0, 2) == 0);
            y_in = W'($urandom);
            ctrl_state = 4'($urandom_range(0, 15));
          end
          default: start = 1'b0;
        endcase
        goto(cyc + 1);
        n++;
      end
      start = 1'b0;
      valid = 1'b0;
      ctrl_state = 4'd0;
      goto(cyc + 1);
      @(negedge clk);
      chk("rand_txn_idle", busy, 1'b0);
    end

    goto(cyc + 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Host-side driver for the differentiator controller's operand-load protocol.
- On a single start command it latches four operands, x, dx, a and u.
- It waits for the controller to enter its read state, then presents each operand on a shared data bus with its one-hot select strobe (s1..s4).
- It asserts ready, then waits for the controller's valid and captures the result.
- It sits between the testbench/host and the controller-plus-datapath, as the transmitter end of the s1..s4/ready/valid interface.

## Interface
- WIDTH, 16, operand and result data width
- HOLD, 2, cycles each strobe is held high (≥1)
- TIMEOUT, 1024, WAIT_VALID watchdog limit in cycles (used only with OPSEQ_TIMEOUT_EN)

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  command pulse; sampled only in IDLE
- x_in, dx_in, a_in, u_in  input  WIDTH each  operands, latched when start accepted
- ctrl_state  input  4  controller state; 4'd1 = read state
- valid  input  1  controller done indication
- y_in  input  WIDTH  datapath result
- data_out  output  WIDTH  shared operand bus to datapath
- s1, s2, s3, s4  output  1 each  one-hot select strobes: x, dx, a, u
- ready  output  1  operands complete, to controller
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when result captured
- y_out  output  WIDTH  captured result, held until next capture or reset
- err  output  1  sticky timeout flag

## Operation
- States: IDLE, WAIT_READ, SEND, GAP, READY, WAIT_VALID, DONE.
- IDLE
  - start=1: latch the four operands, clear err, go to WAIT_READ.
  - start=0: stay in IDLE.
- WAIT_READ: go to SEND with idx=0 when ctrl_state==4'd1.
- SEND
  - Drive strobe s[idx+1]=1 and data_out=operand[idx] for HOLD cycles, using a hold counter.
  - Operand order by idx 0..3: x, dx, a, u.
  - After HOLD cycles, go to GAP.
- GAP
  - One cycle with all strobes 0; data_out holds the last operand.
  - idx<3: idx++, go to SEND.
  - idx==3: go to READY.
- READY: ready=1 and all strobes 0. Go to WAIT_VALID when ctrl_state!=4'd1.
- WAIT_VALID: on valid=1, y_out<=y_in and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Strobes are never more than one high; strobes and ready are never high together.
- start outside IDLE is ignored; operands are not re-latched.
- If ctrl_state leaves 4'd1 during SEND/GAP (controller reset or protocol violation), abort: go to IDLE, all strobes 0, no done.

## Timing
- Reset: every output is 0, including data_out and y_out. State=IDLE, idx=0, counters 0, operand registers 0. Reset mid-operation abandons the transfer immediately.
- Outputs are registered and decoded from state: a change appears the cycle after the causing edge.
- start sampled at edge E, with ctrl_state already 4'd1:
  - s1 high from E+2.
  - Each operand occupies HOLD+1 cycles.
  - ready high from E+2+4·(HOLD+1).
- Minimum ready duration: 1 cycle. ready persists until ctrl_state is observed != 4'd1.
- valid already high on WAIT_VALID entry: capture on the first WAIT_VALID cycle.
- done asserts the cycle after the capture edge. busy drops the same cycle as done deasserts.

## Configuration
- OPSEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_VALID.
  - When it reaches TIMEOUT with no valid: set err=1, go to IDLE, no done, y_out unchanged.
  - err clears on the next accepted start or on reset.
- Undefined: WAIT_VALID waits indefinitely, err is tied 0 and no counter logic exists.

## Test plan
- Reset mid-SEND (during s2) → next cycle all outputs 0, busy=0; a subsequent start gives a normal full sequence.
- Basic load, HOLD=2:
  - Stimulus: start with x=16'h0010, dx=16'h0001, a=16'h0003, u=16'h0005; ctrl_state=1.
  - Required: s1/s2/s3/s4 each high 2 cycles, 1-cycle gaps, data_out matching in order.
  - Required: ready at E+14.
- Handshake:
  - Stimulus: ctrl_state goes 1→2 two cycles after ready; valid=1 with y_in=16'h1234 five cycles later.
  - Required: ready drops, y_out=16'h1234, done pulses once, busy falls.
- WAIT_READ and start handling:
  - Stimulus: start while ctrl_state=0 for 6 cycles, then ctrl_state=1.
  - Required: no strobe until ctrl_state=1, then s1 the next cycle.
  - Required: a second start during SEND changes neither the operands nor the sequence.
- Abort: ctrl_state drops to 0 during s3 → strobes 0 next cycle, IDLE, done never asserts.
- Timeout, OPSEQ_TIMEOUT_EN defined with TIMEOUT=8, valid held 0 → err=1 after 8 WAIT_VALID cycles, IDLE, done=0. With the macro undefined, the sequencer is still busy after 100 cycles and err=0.
